// File: rtl/mux_scan_pkg.sv
// Mode and state encodings shared by the registered scan multiplexer.
package mux_scan_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // mode 2'b11 folds into HOLD
  function automatic logic [1:0] decode_mode(input logic [1:0] m);
    case (m)
      MODE_MANUAL: decode_mode = ST_MANUAL;
      MODE_SCAN:   decode_mode = ST_SCAN;
      default:     decode_mode = ST_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while enabled, flags the last count.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en)         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/mux_scan_reg.sv
// Registered N-channel W-bit multiplexer with manual select, round-robin scan and hold.
module mux_scan_reg
  import mux_scan_pkg::*;
#(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 3,
  parameter  int DWELL    = 4,
  localparam int SELW     = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH*CHANNELS-1:0] d,
  input  logic [SELW-1:0]           sel,
  input  logic [1:0]                mode,
  output logic [WIDTH-1:0]          y,
  output logic [SELW-1:0]           ch,
  output logic                      sel_err,
  output logic                      ch_change
);

  // The mode input selects this edge's behaviour directly, so a mode change
  // lands on the very next edge.
  logic [1:0]       st;
  logic             tick;
  logic             sel_ok;
  logic [SELW-1:0]  ch_wrap;
  logic [WIDTH-1:0] y_nxt;
  logic [SELW-1:0]  ch_nxt;
  logic             err_nxt;

  assign st      = decode_mode(mode);
  assign sel_ok  = {1'b0, sel} < (SELW+1)'(CHANNELS);
  assign ch_wrap = (ch == SELW'(CHANNELS - 1)) ? '0 : ch + SELW'(1);

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (st == ST_SCAN),
    .clr   (st == ST_MANUAL),
    .tick  (tick)
  );

  always_comb begin
    y_nxt   = y;
    ch_nxt  = ch;
    err_nxt = sel_err;
    case (st)
      ST_MANUAL: begin
        if (sel_ok) begin
          ch_nxt  = sel;
          y_nxt   = d[sel*WIDTH +: WIDTH];
          err_nxt = 1'b0;
        end else begin
          err_nxt = 1'b1;
        end
      end
      ST_SCAN: begin
        y_nxt   = d[ch*WIDTH +: WIDTH];
        err_nxt = 1'b0;
        if (tick) ch_nxt = ch_wrap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      ch        <= '0;
      sel_err   <= 1'b0;
      ch_change <= 1'b0;
    end else begin
      y         <= y_nxt;
      ch        <= ch_nxt;
      sel_err   <= err_nxt;
      ch_change <= (ch_nxt != ch);
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
// Scoreboard bench: a default instance under directed+random traffic and a DWELL=1 wide instance.
module tb_mux_scan_reg;

  localparam int WA = 2, CA = 3, DA = 4;
  localparam int WB = 8, CB = 4;

  typedef struct {
    logic [7:0] y;
    logic [1:0] ch;
    logic       err;
    logic       chg;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, rst_b = 1'b0;
  logic [5:0] d_a = '0;
  logic [1:0] sel_a = '0, mode_a = '0;
  logic [1:0] y_a, ch_a;
  logic       err_a, chg_a;

  logic [31:0] d_b = '0;
  logic [1:0]  sel_b = '0, mode_b = '0;
  logic [7:0]  y_b;
  logic [1:0]  ch_b;
  logic        err_b, chg_b;

  mux_scan_reg #(.WIDTH(WA), .CHANNELS(CA), .DWELL(DA)) dut_a (
    .clk(clk), .rst_n(rst_a), .d(d_a), .sel(sel_a), .mode(mode_a),
    .y(y_a), .ch(ch_a), .sel_err(err_a), .ch_change(chg_a));

  mux_scan_reg #(.WIDTH(WB), .CHANNELS(CB), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .d(d_b), .sel(sel_b), .mode(mode_b),
    .y(y_b), .ch(ch_b), .sel_err(err_b), .ch_change(chg_b));

  int tests = 0, fails = 0;
  exp_t qa[$], qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Model A: position in the scan rotation, ch = pos / DWELL, count = pos % DWELL
  int         pos_a = 0;
  logic [1:0] my_a  = '0;
  logic       me_a  = 1'b0;

  task automatic step_a(input logic [1:0] m, input logic [1:0] s, input logic [5:0] dv);
    exp_t e;
    int   oc;
    oc = pos_a / DA;
    if (m == 2'b00) begin
      if (int'(s) < CA) begin
        pos_a = int'(s) * DA;
        my_a  = dv[int'(s)*WA +: WA];
        me_a  = 1'b0;
      end else begin
        pos_a = (pos_a / DA) * DA;
        me_a  = 1'b1;
      end
    end else if (m == 2'b01) begin
      my_a  = dv[(pos_a/DA)*WA +: WA];
      pos_a = (pos_a + 1) % (DA * CA);
      me_a  = 1'b0;
    end
    e.y   = 8'(my_a);
    e.ch  = 2'(pos_a / DA);
    e.err = me_a;
    e.chg = ((pos_a / DA) != oc);
    qa.push_back(e);
  endtask

  task automatic drive_a(input logic [1:0] m, input logic [1:0] s, input logic [5:0] dv);
    @(negedge clk);
    rst_a = 1'b1; mode_a = m; sel_a = s; d_a = dv;
    step_a(m, s, dv);
  endtask

  task automatic reset_a();
    exp_t e;
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("rst_y", 32'(y_a), 0);
    chk("rst_ch", 32'(ch_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_chg", 32'(chg_a), 0);
    pos_a = 0; my_a = '0; me_a = 1'b0;
    e.y = '0; e.ch = '0; e.err = 1'b0; e.chg = 1'b0;
    qa.push_back(e);
  endtask

  // Monitors: every DUT output is a flop, compared each cycle just after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_y", 32'(y_a), 32'(e.y));
      chk("a_ch", 32'(ch_a), 32'(e.ch));
      chk("a_sel_err", 32'(err_a), 32'(e.err));
      chk("a_ch_change", 32'(chg_a), 32'(e.chg));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_y", 32'(y_b), 32'(e.y));
      chk("b_ch", 32'(ch_b), 32'(e.ch));
      chk("b_sel_err", 32'(err_b), 32'(e.err));
      chk("b_ch_change", 32'(chg_b), 32'(e.chg));
    end
  end

  task automatic run_a();
    logic [5:0] dv;
    logic [1:0] m;
    #3;
    chk("init_y", 32'(y_a), 0);
    chk("init_ch", 32'(ch_a), 0);
    // manual select and same-index reselect
    dv = {2'b11, 2'b10, 2'b01};
    drive_a(2'b00, 2'd2, dv);
    drive_a(2'b00, 2'd2, dv);
    // out-of-range hold with error flag
    drive_a(2'b00, 2'd1, dv);
    drive_a(2'b00, 2'd3, dv);
    drive_a(2'b00, 2'd3, dv);
    drive_a(2'b00, 2'd0, dv);
    // full rotation, with channel 1 data toggled mid-dwell
    for (int i = 0; i < 14; i++) begin
      if (i == 6) dv[3:2] = ~dv[3:2];
      drive_a(2'b01, 2'($urandom), dv);
    end
    // park at ch=1 count=2, hold, then resume
    drive_a(2'b00, 2'd0, dv);
    for (int i = 0; i < 6; i++) drive_a(2'b01, 2'd0, dv);
    for (int i = 0; i < 10; i++) drive_a((i % 2 == 0) ? 2'b10 : 2'b11, 2'($urandom), 6'($urandom));
    for (int i = 0; i < 4; i++) drive_a(2'b01, 2'd0, dv);
    // reset mid-scan, restart scanning from ch 0
    reset_a();
    for (int i = 0; i < 9; i++) drive_a(2'b01, 2'd0, 6'($urandom));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) reset_a();
      else begin
        case ($urandom_range(0, 3))
          0: m = 2'b00;
          1, 2: m = 2'b01;
          default: m = 2'($urandom_range(2, 3));
        endcase
        drive_a(m, 2'($urandom), 6'($urandom));
      end
    end
  endtask

  task automatic run_b();
    exp_t e;
    int   chb = 0;
    #3;
    chk("b_init_ch", 32'(ch_b), 0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rst_b = 1'b1; mode_b = 2'b01; sel_b = 2'($urandom); d_b = $urandom;
      e.y   = d_b[chb*WB +: WB];
      chb   = (chb + 1) % CB;
      e.ch  = 2'(chb);
      e.err = 1'b0;
      e.chg = 1'b1;
      qb.push_back(e);
    end
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    @(negedge clk);
    @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
